// File: rtl/as_hdr_parser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : as_hdr_parser_pkg
// Description : Shared constants, state encodings and info-FIFO entry layout
//               for the anti-spoof header parser.
// Revision    : 1.0 - initial release
// ============================================================================
package as_hdr_parser_pkg;

    localparam logic [7:0]  DEFAULT_IO_QUEUE_STAGE_NUM = 8'hFF;
    localparam logic [15:0] ETHERTYPE_IP               = 16'h0800;
    localparam logic [3:0]  IP_VERSION_4               = 4'd4;

    // Ethernet/IP word indices after the module headers
    localparam int W0 = 0;
    localparam int W1 = 1;
    localparam int W2 = 2;
    localparam int W3 = 3;
    localparam int W4 = 4;

    // One-hot parse states; the bit index of each word state is its word index
    typedef enum logic [5:0] {
        P_MOD_HDRS = 6'(1 << W0),
        P_W1       = 6'(1 << W1),
        P_W2       = 6'(1 << W2),
        P_W3       = 6'(1 << W3),
        P_W4       = 6'(1 << W4),
        P_WAIT_EOP = 6'(1 << (W4 + 1))
    } parse_state_t;

    typedef enum logic [2:0] {
        L_IDLE  = 3'b001,
        L_REQ   = 3'b010,
        L_DRAIN = 3'b100
    } lookup_state_t;

    // Entry layout, LSB first: dst_mac, src_mac, dst_ip, src_ip, src_port, is_ip
    localparam int OFF_DST_MAC  = 0;
    localparam int OFF_SRC_MAC  = 48;
    localparam int OFF_DST_IP   = 96;
    localparam int OFF_SRC_IP   = 128;
    localparam int OFF_SRC_PORT = 160;

    function automatic int off_is_ip(input int iq_bits);
        return OFF_SRC_PORT + iq_bits;
    endfunction

    function automatic int entry_width(input int iq_bits);
        return off_is_ip(iq_bits) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/as_hdr_info_fifo.sv
`default_nettype none
// ============================================================================
// Module      : as_hdr_info_fifo
// Description : Register-based first-word-fall-through FIFO for header info.
// Revision    : 1.0 - initial release
// ============================================================================
module as_hdr_info_fifo #(
    parameter int WIDTH      = 164,
    parameter int DEPTH_BITS = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int c_depth = 2 ** DEPTH_BITS;

    logic [WIDTH-1:0]      r_mem [c_depth];
    logic [DEPTH_BITS-1:0] r_wr_ptr;
    logic [DEPTH_BITS-1:0] r_rd_ptr;
    logic [DEPTH_BITS:0]   r_count;
    logic                  w_push;
    logic                  w_pop;

    assign full    = (r_count == (DEPTH_BITS + 1)'(c_depth));
    assign empty   = (r_count == '0);
    assign w_push  = wr_en && !full;
    assign w_pop   = rd_en && !empty;
    assign rd_data = r_mem[r_rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage is cleared so the head fields read as zero after reset
    generate
        for (genvar i = 0; i < c_depth; i++) begin : g_mem
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_mem[i] <= '0;
                end else if (w_push && (r_wr_ptr == DEPTH_BITS'(i))) begin
                    r_mem[i] <= wr_data;
                end
            end
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/as_hdr_parser.sv
`default_nettype none
// ============================================================================
// Module      : as_hdr_parser
// Description : Snoops the packet stream, extracts MAC/IP/port header info,
//               queues it and drives the anti-spoof LUT request handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module as_hdr_parser
    import as_hdr_parser_pkg::*;
#(
    parameter int                    DATA_WIDTH           = 64,
    parameter int                    CTRL_WIDTH           = 8,
    parameter int                    NUM_OUTPUT_QUEUES    = 8,
    parameter int                    NUM_IQ_BITS          = 3,
    parameter int                    INFO_FIFO_DEPTH_BITS = 1,
    parameter logic [CTRL_WIDTH-1:0] IO_QUEUE_STAGE_NUM   = CTRL_WIDTH'(DEFAULT_IO_QUEUE_STAGE_NUM)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        in_data,
    input  logic [CTRL_WIDTH-1:0]        in_ctrl,
    input  logic                         in_wr,
    output logic                         in_rdy,
    output logic                         lookup_req,
    output logic [47:0]                  dst_mac,
    output logic [47:0]                  src_mac,
    output logic [31:0]                  dst_ip,
    output logic [31:0]                  src_ip,
    output logic [NUM_IQ_BITS-1:0]       src_port,
    input  logic                         lookup_ack,
    input  logic [NUM_OUTPUT_QUEUES-1:0] lut_dst_ports,
    output logic                         result_vld,
    output logic [NUM_OUTPUT_QUEUES-1:0] result_ports,
    output logic [31:0]                  num_pkts,
    output logic [31:0]                  num_non_ip
);
    localparam int c_entry_w  = entry_width(NUM_IQ_BITS);
    localparam int c_is_ip_bit = off_is_ip(NUM_IQ_BITS);

    parse_state_t            r_pstate;
    lookup_state_t           r_lstate;
    logic [NUM_IQ_BITS-1:0]  r_src_port;
    logic [47:0]             r_dst_mac;
    logic [47:0]             r_src_mac;
    logic [31:0]             r_src_ip;
    logic [31:0]             r_dst_ip;
    logic                    r_is_ip;

    logic [47:0]             w_src_mac;
    logic [31:0]             w_src_ip;
    logic [31:0]             w_dst_ip;
    logic                    w_is_ip;
    logic                    w_push;
    logic                    w_full_hdr;
    logic                    w_push_ip;
    logic                    w_eop;
    logic [c_entry_w-1:0]    w_push_data;
    logic [c_entry_w-1:0]    w_head;
    logic                    w_head_is_ip;
    logic                    w_pop;
    logic                    w_fifo_full;
    logic                    w_fifo_empty;

    assign w_eop = (in_ctrl != '0);

    // Header view including the current word, so a push captures it directly
    always_comb begin
        w_src_mac  = r_src_mac;
        w_src_ip   = r_src_ip;
        w_dst_ip   = r_dst_ip;
        w_is_ip    = r_is_ip;
        w_push     = 1'b0;
        w_full_hdr = 1'b0;
        if (in_wr) begin
            case (r_pstate)
                P_W1: begin
                    w_src_mac[31:0] = in_data[63:32];
                    w_is_ip         = (in_data[31:16] == ETHERTYPE_IP) &&
                                      (in_data[15:12] == IP_VERSION_4);
                    w_push          = w_eop;
                end
                P_W2: begin
                    w_push = w_eop;
                end
                P_W3: begin
                    w_src_ip         = in_data[47:16];
                    w_dst_ip[31:16]  = in_data[15:0];
                    w_push           = w_eop;
                end
                P_W4: begin
                    w_dst_ip[15:0] = in_data[63:48];
                    w_push         = 1'b1;
                    w_full_hdr     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // A packet ending before W4 never carries a complete IP header
    assign w_push_ip   = w_is_ip && w_full_hdr;
    assign w_push_data = {w_push_ip,
                          r_src_port,
                          w_push_ip ? w_src_ip : 32'd0,
                          w_push_ip ? w_dst_ip : 32'd0,
                          w_src_mac,
                          r_dst_mac};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pstate   <= P_MOD_HDRS;
            r_src_port <= '0;
            r_dst_mac  <= '0;
            r_src_mac  <= '0;
            r_src_ip   <= '0;
            r_dst_ip   <= '0;
            r_is_ip    <= 1'b0;
            num_pkts   <= '0;
            num_non_ip <= '0;
        end else if (in_wr) begin
            case (r_pstate)
                P_MOD_HDRS: begin
                    if (in_ctrl == IO_QUEUE_STAGE_NUM) begin
                        r_src_port <= in_data[16 +: NUM_IQ_BITS];
                    end else if (!w_eop) begin
                        r_dst_mac <= in_data[63:16];
                        r_src_mac <= {in_data[15:0], 32'd0};
                        r_src_ip  <= '0;
                        r_dst_ip  <= '0;
                        r_is_ip   <= 1'b0;
                        r_pstate  <= P_W1;
                    end
                end
                P_W1: begin
                    r_src_mac <= w_src_mac;
                    r_is_ip   <= w_is_ip;
                    r_pstate  <= w_eop ? P_MOD_HDRS : P_W2;
                end
                P_W2: begin
                    r_pstate <= w_eop ? P_MOD_HDRS : P_W3;
                end
                P_W3: begin
                    r_src_ip <= w_src_ip;
                    r_dst_ip <= w_dst_ip;
                    r_pstate <= w_eop ? P_MOD_HDRS : P_W4;
                end
                P_W4: begin
                    r_dst_ip <= w_dst_ip;
                    r_pstate <= w_eop ? P_MOD_HDRS : P_WAIT_EOP;
                end
                P_WAIT_EOP: begin
                    if (w_eop) begin
                        r_pstate <= P_MOD_HDRS;
                    end
                end
                default: r_pstate <= P_MOD_HDRS;
            endcase
            if (w_push) begin
                num_pkts <= num_pkts + 32'd1;
                if (!w_push_ip) begin
                    num_non_ip <= num_non_ip + 32'd1;
                end
            end
        end
    end

    as_hdr_info_fifo #(
        .WIDTH      (c_entry_w),
        .DEPTH_BITS (INFO_FIFO_DEPTH_BITS)
    ) u_info_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (w_push),
        .wr_data (w_push_data),
        .rd_en   (w_pop),
        .rd_data (w_head),
        .full    (w_fifo_full),
        .empty   (w_fifo_empty)
    );

    assign in_rdy       = !w_fifo_full;
    assign w_head_is_ip = w_head[c_is_ip_bit];
    assign dst_mac      = w_head[OFF_DST_MAC +: 48];
    assign src_mac      = w_head[OFF_SRC_MAC +: 48];
    assign dst_ip       = w_head_is_ip ? w_head[OFF_DST_IP +: 32] : 32'd0;
    assign src_ip       = w_head_is_ip ? w_head[OFF_SRC_IP +: 32] : 32'd0;
    assign src_port     = w_head[OFF_SRC_PORT +: NUM_IQ_BITS];
    assign w_pop        = (r_lstate == L_REQ) && lookup_ack;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_lstate     <= L_IDLE;
            lookup_req   <= 1'b0;
            result_vld   <= 1'b0;
            result_ports <= '0;
        end else begin
            result_vld <= 1'b0;
            case (r_lstate)
                L_IDLE: begin
                    if (!w_fifo_empty && !lookup_ack) begin
                        lookup_req <= 1'b1;
                        r_lstate   <= L_REQ;
                    end
                end
                L_REQ: begin
                    if (lookup_ack) begin
                        result_ports <= lut_dst_ports;
                        result_vld   <= 1'b1;
                        lookup_req   <= 1'b0;
                        r_lstate     <= L_DRAIN;
                    end
                end
                L_DRAIN: begin
                    if (!lookup_ack) begin
                        r_lstate <= L_IDLE;
                    end
                end
                default: begin
                    lookup_req <= 1'b0;
                    r_lstate   <= L_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_as_hdr_parser.sv
`default_nettype none
// ============================================================================
// Module      : tb_as_hdr_parser
// Description : Directed bench with LUT responder and in-order result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_as_hdr_parser;

    typedef struct {
        logic [47:0] dmac;
        logic [47:0] smac;
        logic [31:0] sip;
        logic [31:0] dip;
        logic [2:0]  port;
        logic [7:0]  ports;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [63:0] in_data = '0;
    logic [7:0]  in_ctrl = '0;
    logic        in_wr = 1'b0;
    logic        in_rdy;
    logic        lookup_req;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [31:0] dst_ip;
    logic [31:0] src_ip;
    logic [2:0]  src_port;
    logic        lookup_ack = 1'b0;
    logic [7:0]  lut_dst_ports = '0;
    logic        result_vld;
    logic [7:0]  result_ports;
    logic [31:0] num_pkts;
    logic [31:0] num_non_ip;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   n_results = 0;
    int   ack_hold = 1;
    int   ack_age = 0;
    bit   lut_en = 1'b1;
    int   exp_pkts = 0;
    int   exp_non_ip = 0;

    as_hdr_parser dut (
        .clk           (clk),
        .reset         (reset),
        .in_data       (in_data),
        .in_ctrl       (in_ctrl),
        .in_wr         (in_wr),
        .in_rdy        (in_rdy),
        .lookup_req    (lookup_req),
        .dst_mac       (dst_mac),
        .src_mac       (src_mac),
        .dst_ip        (dst_ip),
        .src_ip        (src_ip),
        .src_port      (src_port),
        .lookup_ack    (lookup_ack),
        .lut_dst_ports (lut_dst_ports),
        .result_vld    (result_vld),
        .result_ports  (result_ports),
        .num_pkts      (num_pkts),
        .num_non_ip    (num_non_ip)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // LUT model and result scoreboard, evaluated away from the active edge
    always @(negedge clk) begin
        if (reset) begin
            lookup_ack = 1'b0;
            ack_age    = 0;
        end else begin
            if (result_vld) begin
                n_results++;
                check("result_pending", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    check("result_ports", 64'(result_ports), 64'(exp_q[0].ports));
                    void'(exp_q.pop_front());
                end
            end
            if (lookup_ack) begin
                ack_age++;
                check("req_low_during_ack", 64'(lookup_req), 64'd0);
                if (ack_age >= ack_hold && !lookup_req) begin
                    lookup_ack = 1'b0;
                end
            end else if (lookup_req && lut_en) begin
                check("req_pending", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) begin
                    check("req_dst_mac",  64'(dst_mac),  64'(exp_q[0].dmac));
                    check("req_src_mac",  64'(src_mac),  64'(exp_q[0].smac));
                    check("req_src_ip",   64'(src_ip),   64'(exp_q[0].sip));
                    check("req_dst_ip",   64'(dst_ip),   64'(exp_q[0].dip));
                    check("req_src_port", 64'(src_port), 64'(exp_q[0].port));
                    lut_dst_ports = exp_q[0].ports;
                end
                lookup_ack = 1'b1;
                ack_age    = 0;
            end
        end
    end

    task automatic send_word(input logic [63:0] d, input logic [7:0] c);
        int n = 0;
        @(negedge clk);
        in_wr = 1'b0;
        while (!in_rdy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!in_rdy) check("in_rdy_timeout", 64'(in_rdy), 64'd1);
        in_data = d;
        in_ctrl = c;
        in_wr   = 1'b1;
    endtask

    task automatic send_pkt(input logic [2:0] port, input logic [47:0] dmac, input logic [47:0] smac,
                            input logic [15:0] etype, input logic [31:0] sip, input logic [31:0] dip,
                            input int last, input logic [7:0] ports);
        logic [63:0] w [6];
        exp_t        e;
        bit          ip;
        w[0] = {dmac, smac[47:32]};
        w[1] = {smac[31:0], etype, 16'h4500};
        w[2] = 64'h1234_0000_4006_0000;
        w[3] = {16'hBEEF, sip, dip[31:16]};
        w[4] = {dip[15:0], 48'h0001_0002_0003};
        w[5] = 64'hDEAD_BEEF_CAFE_F00D;
        ip = (etype == 16'h0800) && (last >= 4);
        e.dmac  = dmac;
        e.smac  = smac;
        e.sip   = ip ? sip : 32'd0;
        e.dip   = ip ? dip : 32'd0;
        e.port  = port;
        e.ports = ports;
        exp_q.push_back(e);
        exp_pkts++;
        if (!ip) exp_non_ip++;
        send_word({45'd0, port, 16'd0}, 8'hFF);
        for (int i = 0; i <= last; i++) begin
            send_word(w[i], (i == last) ? 8'h01 : 8'h00);
        end
        @(negedge clk);
        in_wr   = 1'b0;
        in_ctrl = 8'h00;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((exp_q.size() != 0 || lookup_req || lookup_ack) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_counters();
        check("num_pkts",   64'(num_pkts),   64'(exp_pkts));
        check("num_non_ip", 64'(num_non_ip), 64'(exp_non_ip));
    endtask

    initial begin
        int res_base;

        #1 reset = 1'b1;
        #2;
        check("rst_lookup_req",   64'(lookup_req),   64'd0);
        check("rst_result_vld",   64'(result_vld),   64'd0);
        check("rst_result_ports", 64'(result_ports), 64'd0);
        check("rst_in_rdy",       64'(in_rdy),       64'd1);
        check("rst_dst_mac",      64'(dst_mac),      64'd0);
        check_counters();
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // IPv4 packet; request rises two cycles after the W4 word is accepted
        send_pkt(3'd2, 48'h0011_2233_4455, 48'hAABB_CCDD_EEFF, 16'h0800,
                 32'h0A00_0001, 32'h0A00_0002, 5, 8'h04);
        check("req_latency", 64'(lookup_req), 64'd1);
        wait_idle();
        check_counters();
        check("results_ipv4", 64'(n_results), 64'd1);

        // ARP: IPs forced to zero
        send_pkt(3'd1, 48'hFFFF_FFFF_FFFF, 48'h0200_0000_0001, 16'h0806,
                 32'hC0A8_0001, 32'hC0A8_0002, 5, 8'h10);
        wait_idle();
        check_counters();

        // Runt: EOP on W2
        send_pkt(3'd6, 48'h0A0B_0C0D_0E0F, 48'h1122_3344_5566, 16'h0800,
                 32'h0101_0101, 32'h0202_0202, 2, 8'h21);
        wait_idle();
        check_counters();

        // Backpressure: two entries fill the FIFO while acks are withheld
        lut_en = 1'b0;
        send_pkt(3'd3, 48'h0000_0000_0A01, 48'h0000_0000_0B01, 16'h0800,
                 32'h0A01_0101, 32'h0B01_0101, 4, 8'h01);
        check("in_rdy_one_entry", 64'(in_rdy), 64'd1);
        send_pkt(3'd4, 48'h0000_0000_0A02, 48'h0000_0000_0B02, 16'h0800,
                 32'h0A02_0202, 32'h0B02_0202, 4, 8'h02);
        check("in_rdy_full", 64'(in_rdy), 64'd0);
        lut_en = 1'b1;
        send_pkt(3'd5, 48'h0000_0000_0A03, 48'h0000_0000_0B03, 16'h0800,
                 32'h0A03_0303, 32'h0B03_0303, 4, 8'h03);
        wait_idle();
        check_counters();
        check("results_bp", 64'(n_results), 64'd6);

        // Long ack: request stays low, single result
        ack_hold = 5;
        send_pkt(3'd7, 48'h5566_7788_99AA, 48'h0123_4567_89AB, 16'h0800,
                 32'hAC10_0001, 32'hAC10_00FE, 5, 8'h80);
        wait_idle();
        ack_hold = 1;
        check("results_hold", 64'(n_results), 64'd7);

        // Reset mid-W3 with a request pending and a partial header in flight
        lut_en = 1'b0;
        send_pkt(3'd1, 48'h0F0E_0D0C_0B0A, 48'h0908_0706_0504, 16'h0800,
                 32'h0303_0303, 32'h0404_0404, 5, 8'h55);
        repeat (3) @(negedge clk);
        check("pre_rst_req", 64'(lookup_req), 64'd1);
        check_counters();
        send_word({45'd0, 3'd2, 16'd0}, 8'hFF);
        send_word(64'h1111_2222_3333_4444, 8'h00);
        send_word(64'h5555_6666_0800_4500, 8'h00);
        send_word(64'h0000_0000_4006_0000, 8'h00);
        send_word(64'hBEEF_0909_0909_0808, 8'h00);
        #2 reset = 1'b1;
        in_wr = 1'b0;
        #1;
        check("mid_rst_lookup_req",   64'(lookup_req),   64'd0);
        check("mid_rst_result_ports", 64'(result_ports), 64'd0);
        check("mid_rst_in_rdy",       64'(in_rdy),       64'd1);
        check("mid_rst_dst_mac",      64'(dst_mac),      64'd0);
        exp_q.delete();
        exp_pkts   = 0;
        exp_non_ip = 0;
        check_counters();
        lut_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        res_base = n_results;
        send_pkt(3'd5, 48'h00AA_BBCC_DDEE, 48'h0011_2233_4466, 16'h0800,
                 32'h0A0A_0A0A, 32'h0B0B_0B0B, 5, 8'hC3);
        wait_idle();
        check_counters();
        check("results_post_rst", 64'(n_results), 64'(res_base + 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/as_hdr_parser.md
# as_hdr_parser

Upstream neighbour of the anti-spoof MAC CAM lookup stage. It snoops the 64-bit NetFPGA packet stream and takes the input port from the IOQ module header. It extracts dst/src MAC and, for IPv4, src/dst IP, then queues them and drives the lookup request/ack handshake into the LUT. Each returned `dst_ports` word is presented to the downstream port-insert logic as a one-cycle result strobe.

## Interface
Parameters:
- `DATA_WIDTH`, 64, packet data width
- `CTRL_WIDTH`, 8, packet ctrl width
- `NUM_OUTPUT_QUEUES`, 8, width of `dst_ports`
- `NUM_IQ_BITS`, 3, width of `src_port`
- `INFO_FIFO_DEPTH_BITS`, 1, log2 depth of the header-info FIFO
- `IO_QUEUE_STAGE_NUM`, 8'hFF, ctrl value marking the IOQ module header

Ports:
- `clk`  in  1  single clock
- `reset`  in  1  asynchronous, active-high
- `in_data`  in  64  packet word
- `in_ctrl`  in  8  packet ctrl
- `in_wr`  in  1  word valid
- `in_rdy`  out  1  `!info_fifo_full`; upstream must not assert `in_wr` while low
- `lookup_req`  out  1  level request to LUT
- `dst_mac`, `src_mac`  out  48 each  FIFO head fields
- `dst_ip`, `src_ip`  out  32 each  FIFO head fields; 0 if non-IPv4
- `src_port`  out  `NUM_IQ_BITS`  FIFO head field
- `lookup_ack`  in  1  LUT ack; stays high until `lookup_req` is low
- `lut_dst_ports`  in  `NUM_OUTPUT_QUEUES`  LUT result; valid while `lookup_ack` is high
- `result_vld`  out  1  one-cycle strobe
- `result_ports`  out  `NUM_OUTPUT_QUEUES`  captured result
- `num_pkts`, `num_non_ip`  out  32 each  wrapping counters

## Operation
Parse FSM advances only on `in_wr`:
- **MOD_HDRS**
  - `in_ctrl==IO_QUEUE_STAGE_NUM`: latch `src_port = in_data[16+NUM_IQ_BITS-1:16]`.
  - Other nonzero ctrl: ignore.
  - `in_ctrl==0`: this is W0. Latch `dst_mac=[63:16]` and `src_mac[47:32]=[15:0]`, then go to W1.
- **W1**: `src_mac[31:0]=[63:32]`. `is_ip = ([31:16]==16'h0800) && ([15:12]==4)`.
- **W2**: no fields.
- **W3**: `src_ip=[47:16]`, `dst_ip[31:16]=[15:0]`.
- **W4**: `dst_ip[15:0]=[63:48]`. Push, then go to WAIT_EOP. If this word is also EOP (`in_ctrl!=0`), go straight to MOD_HDRS.
- **WAIT_EOP**: on `in_ctrl!=0` go to MOD_HDRS.
- **Early EOP**: a nonzero ctrl in W1..W3 pushes immediately and returns to MOD_HDRS. Fields not yet received are 0; the entry is marked non-IP.
- **Push**:
  - Write one FIFO entry with IPs forced to 0 when `!is_ip`.
  - Increment `num_pkts`; increment `num_non_ip` when `!is_ip`.
  - Exactly one push per packet.

Lookup FSM:
- **L_IDLE**: FIFO non-empty and `lookup_ack==0` → `lookup_req<=1`, go to L_REQ.
- **L_REQ**: on `lookup_ack==1`:
  - `result_ports<=lut_dst_ports`, `result_vld<=1` for one cycle.
  - Pop the FIFO, `lookup_req<=0`, go to L_DRAIN.
- **L_DRAIN**: wait for `lookup_ack==0`, then go to L_IDLE. `lookup_req` is never reasserted while ack is high.

Request outputs are driven from the FIFO head, so they are stable for the whole time `lookup_req` is high.

Simultaneous push and pop in one cycle is legal; occupancy is unchanged.

## Timing
- Reset (async) clears:
  - `lookup_req`, `result_vld`, `result_ports`, both counters
  - FIFO (empty), so `in_rdy`=1
  - Parse FSM to MOD_HDRS, lookup FSM to L_IDLE
- Header fields reset to 0.
- Push is registered. The FIFO is non-empty the cycle after the W4 (or early-EOP) edge, and `lookup_req` rises one cycle later.
- `result_vld` rises on the edge after the first `lookup_ack` high sample.
- Minimum spacing between two requests: the ack-drop cycle plus one idle cycle.
- `in_rdy` is combinational from FIFO full. A push is never attempted when full.
- Reset mid-packet discards the partial header. Parsing resumes at MOD_HDRS, so the remainder of that packet is treated as a new packet's module headers. The LUT must share the same reset.

## Structure
- Shared package holds:
  - `IO_QUEUE_STAGE_NUM` default
  - `ETHERTYPE_IP = 16'h0800`
  - Word-index constants W0..W4
  - One-hot parse and lookup state encodings
  - FIFO entry field offsets (`is_ip`, `src_port`, `src_ip`, `dst_ip`, `src_mac`, `dst_mac`)
- One sub-module, `as_hdr_info_fifo`:
  - Register-based first-word-fall-through FIFO
  - Width `1+NUM_IQ_BITS+32+32+48+48`, depth `2**INFO_FIFO_DEPTH_BITS`
  - Provides `full`/`empty`

## Test plan
- **IPv4 packet**: IOQ hdr src port 2; dst_mac 0x001122334455, src_mac 0xAABBCCDDEEFF, src_ip 0x0A000001, dst_ip 0x0A000002; LUT model acks with 8'h04. Expect one request carrying exactly those fields, then `result_vld` once with 8'h04; `num_pkts`=1.
- **ARP packet** (ethertype 0x0806): expect a request with both IPs=0; `num_non_ip`=1.
- **Runt**: EOP on W2. Expect a push with IPs=0 and `src_mac` complete, marked non-IP.
- **Backpressure**: three back-to-back packets with the LUT ack withheld. `in_rdy` must drop after 2 pushes, no entry may be lost, and three results must come out in order once acks resume.
- **Handshake**: LUT holds ack high for 5 cycles. `lookup_req` must drop the cycle after the ack sample and stay low until ack is low; no double `result_vld`.
- **Reset mid-W3**: async assert. All outputs return to reset values immediately, and the next full packet parses correctly.
